// File: rtl/light_monitor_if.sv
// Signal bundle between the traffic-light color stream and its monitor.
// The sample side drives the master modport; light_monitor sits on the slave modport.
interface light_monitor_if;
    logic       en;
    logic [1:0] color;
    logic       clr_err;
    logic       locked;
    logic [1:0] cur_color;
    logic       seq_err;
    logic       code_err;
    logic       dwell_err;
    logic       err_sticky;
    logic [7:0] cycle_count;

    modport master (
        output en, color, clr_err,
        input  locked, cur_color, seq_err, code_err, dwell_err, err_sticky, cycle_count
    );

    modport slave (
        input  en, color, clr_err,
        output locked, cur_color, seq_err, code_err, dwell_err, err_sticky, cycle_count
    );
endinterface

// File: rtl/light_monitor.sv
// Locks onto the red->green->yellow color stream, enforces per-color dwell
// limits, flags illegal codes and out-of-order changes, counts light cycles.
//
// state  | meaning
// SYNC   | not tracking; waiting for a red sample to lock
// RED    | locked, last accepted color red
// GREEN  | locked, last accepted color green
// YELLOW | locked, last accepted color yellow
module light_monitor #(
    parameter int MIN_DWELL = 1,
    parameter int MAX_DWELL = 1
) (
    input  logic           clk,
    input  logic           reset,
    light_monitor_if.slave mon
);
    typedef enum logic [1:0] {SYNC, RED, GREEN, YELLOW} state_t;

    localparam logic [7:0] MIN_D = 8'(MIN_DWELL);
    localparam logic [7:0] MAX_D = 8'(MAX_DWELL);

    state_t     state_q, state_d;
    logic [7:0] dwell_q, dwell_d;
    logic [7:0] count_q, count_d;
    logic       seq_err_q, seq_err_d;
    logic       code_err_q, code_err_d;
    logic       dwell_err_q, dwell_err_d;
    logic       sticky_q, sticky_d;
    logic       locked_q, locked_d;
    logic [1:0] cur_color_q, cur_color_d;

    function automatic logic [1:0] color_of(input state_t s);
        case (s)
            RED:     color_of = 2'b00;
            GREEN:   color_of = 2'b01;
            YELLOW:  color_of = 2'b10;
            default: color_of = 2'b00;
        endcase
    endfunction

    function automatic state_t next_of(input state_t s);
        case (s)
            RED:     next_of = GREEN;
            GREEN:   next_of = YELLOW;
            YELLOW:  next_of = RED;
            default: next_of = SYNC;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        dwell_d     = dwell_q;
        count_d     = count_q;
        seq_err_d   = 1'b0;
        code_err_d  = 1'b0;
        dwell_err_d = 1'b0;
        if (mon.en) begin
            if (mon.color == 2'b11) begin
                code_err_d = 1'b1;
                state_d    = SYNC;
                dwell_d    = 8'd0;
            end else if (state_q == SYNC) begin
                if (mon.color == 2'b00) begin
                    state_d = RED;
                    dwell_d = 8'd1;
                end
            end else if (mon.color == color_of(state_q)) begin
                if (dwell_q < MAX_D) begin
                    dwell_d = dwell_q + 8'd1;
                end else begin
                    dwell_err_d = 1'b1;
                    state_d     = SYNC;
                    dwell_d     = 8'd0;
                end
            end else if (mon.color == color_of(next_of(state_q))) begin
                if (dwell_q < MIN_D) begin
                    dwell_err_d = 1'b1;
                    state_d     = SYNC;
                    dwell_d     = 8'd0;
                end else begin
                    state_d = next_of(state_q);
                    dwell_d = 8'd1;
                    if (state_q == YELLOW) count_d = count_q + 8'd1;
                end
            end else begin
                seq_err_d = 1'b1;
                state_d   = SYNC;
                dwell_d   = 8'd0;
            end
        end
        // clear acts even with en low; a same-edge error still sets
        sticky_d    = seq_err_d | code_err_d | dwell_err_d | (sticky_q & ~mon.clr_err);
        locked_d    = (state_d != SYNC);
        cur_color_d = color_of(state_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= SYNC;
            dwell_q     <= 8'd0;
            count_q     <= 8'd0;
            seq_err_q   <= 1'b0;
            code_err_q  <= 1'b0;
            dwell_err_q <= 1'b0;
            sticky_q    <= 1'b0;
            locked_q    <= 1'b0;
            cur_color_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            dwell_q     <= dwell_d;
            count_q     <= count_d;
            seq_err_q   <= seq_err_d;
            code_err_q  <= code_err_d;
            dwell_err_q <= dwell_err_d;
            sticky_q    <= sticky_d;
            locked_q    <= locked_d;
            cur_color_q <= cur_color_d;
        end
    end

    assign mon.locked      = locked_q;
    assign mon.cur_color   = cur_color_q;
    assign mon.seq_err     = seq_err_q;
    assign mon.code_err    = code_err_q;
    assign mon.dwell_err   = dwell_err_q;
    assign mon.err_sticky  = sticky_q;
    assign mon.cycle_count = count_q;
endmodule

// File: tb/tb_light_monitor.sv
// Bench for light_monitor: a default-dwell instance and a MIN=2/MAX=3 instance
// share one directed stimulus stream; each is checked every cycle against its model.
module tb_light_monitor;
    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [1:0] color;
    logic       clr_err;

    int n_chk  = 0;
    int n_fail = 0;

    light_monitor_if ifa ();
    light_monitor_if ifb ();

    assign ifa.en = en;  assign ifa.color = color;  assign ifa.clr_err = clr_err;
    assign ifb.en = en;  assign ifb.color = color;  assign ifb.clr_err = clr_err;

    light_monitor dut_a (.clk(clk), .reset(reset), .mon(ifa));
    light_monitor #(.MIN_DWELL(2), .MAX_DWELL(3)) dut_b (.clk(clk), .reset(reset), .mon(ifb));

    always #5 clk = ~clk;

    // Model: a locked flag, the last accepted color, its run length and the cycle tally.
    typedef struct {
        bit       lk;
        bit [1:0] col;
        int       run;
        bit [7:0] cnt;
        bit       se, ce, de, st;
    } mstate_t;

    mstate_t ma = '{default: 0};
    mstate_t mb = '{default: 0};

    function automatic mstate_t mstep(input mstate_t s, input bit e, input bit [1:0] c,
                                      input bit clr, input int mn, input int mx);
        mstate_t  n;
        bit [1:0] nxt;
        n = s;
        n.se = 0; n.ce = 0; n.de = 0;
        nxt = (s.col == 2'd2) ? 2'd0 : s.col + 2'd1;
        if (e) begin
            if (c == 2'd3) begin
                n.ce = 1; n.lk = 0; n.run = 0;
            end else if (!s.lk) begin
                if (c == 2'd0) begin n.lk = 1; n.col = 2'd0; n.run = 1; end
            end else if (c == s.col) begin
                if (s.run >= mx) begin n.de = 1; n.lk = 0; n.run = 0; end
                else n.run = s.run + 1;
            end else if (c == nxt) begin
                if (s.run < mn) begin
                    n.de = 1; n.lk = 0; n.run = 0;
                end else begin
                    if (s.col == 2'd2) n.cnt = s.cnt + 8'd1;
                    n.col = c; n.run = 1;
                end
            end else begin
                n.se = 1; n.lk = 0; n.run = 0;
            end
        end
        n.st = (s.st && !clr) || n.se || n.ce || n.de;
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ma = '{default: 0};
            mb = '{default: 0};
        end else begin
            ma = mstep(ma, en, color, clr_err, 1, 1);
            mb = mstep(mb, en, color, clr_err, 2, 3);
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cmp_all(input string tag, input logic lk, input logic [1:0] cc,
                           input logic se, input logic ce, input logic de, input logic st,
                           input logic [7:0] cnt, input mstate_t m);
        check({tag, ".locked"},      8'(lk),  8'(m.lk));
        check({tag, ".cur_color"},   8'(cc),  m.lk ? 8'(m.col) : 8'd0);
        check({tag, ".seq_err"},     8'(se),  8'(m.se));
        check({tag, ".code_err"},    8'(ce),  8'(m.ce));
        check({tag, ".dwell_err"},   8'(de),  8'(m.de));
        check({tag, ".err_sticky"},  8'(st),  8'(m.st));
        check({tag, ".cycle_count"}, cnt,     m.cnt);
    endtask

    always @(negedge clk) begin
        cmp_all("a", ifa.locked, ifa.cur_color, ifa.seq_err, ifa.code_err, ifa.dwell_err,
                ifa.err_sticky, ifa.cycle_count, ma);
        cmp_all("b", ifb.locked, ifb.cur_color, ifb.seq_err, ifb.code_err, ifb.dwell_err,
                ifb.err_sticky, ifb.cycle_count, mb);
    end

    // Called at a negedge; the following posedge samples, and it returns at the next negedge.
    task automatic tick(input logic e, input logic [1:0] c, input logic clr);
        en = e; color = c; clr_err = clr;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; color = 2'b00; clr_err = 1'b0;
        #12;
        check("rst_locked", 8'(ifa.locked), 8'd0);
        check("rst_count",  ifa.cycle_count, 8'd0);
        check("rst_sticky", 8'(ifa.err_sticky), 8'd0);
        @(negedge clk);
        reset = 1'b1;

        // legal sequence at default dwell
        tick(1, 2'd0, 0);
        check("t1_first_lock", 8'(ifa.locked), 8'd1);
        for (int i = 0; i < 3; i++) begin
            tick(1, 2'd1, 0); tick(1, 2'd2, 0); tick(1, 2'd0, 0);
        end
        check("t1_count",  ifa.cycle_count, 8'd3);
        check("t1_sticky", 8'(ifa.err_sticky), 8'd0);
        tick(0, 2'd0, 1);

        // illegal code while green
        tick(1, 2'd1, 0);
        check("t2_green", 8'(ifa.cur_color), 8'd1);
        tick(1, 2'd3, 0);
        check("t2_code_err", 8'(ifa.code_err), 8'd1);
        check("t2_unlocked", 8'(ifa.locked), 8'd0);
        check("t2_cur_sync", 8'(ifa.cur_color), 8'd0);
        check("t2_sticky",   8'(ifa.err_sticky), 8'd1);
        tick(1, 2'd0, 0);
        check("t2_relock",   8'(ifa.locked), 8'd1);
        check("t2_pulse_end", 8'(ifa.code_err), 8'd0);

        // out-of-order while red
        tick(1, 2'd2, 0);
        check("t3_seq_err",  8'(ifa.seq_err), 8'd1);
        check("t3_unlocked", 8'(ifa.locked), 8'd0);
        tick(1, 2'd0, 0);
        check("t3_relock", 8'(ifa.locked), 8'd1);
        check("t3_count",  ifa.cycle_count, 8'd3);
        tick(0, 2'd0, 1);

        // dwell limits on the MIN=2/MAX=3 instance
        tick(1, 2'd3, 0);
        tick(1, 2'd0, 0); tick(1, 2'd0, 0); tick(1, 2'd1, 0);
        tick(1, 2'd2, 0);
        check("t4_short_green", 8'(ifb.dwell_err), 8'd1);
        tick(1, 2'd0, 0); tick(1, 2'd0, 0);
        tick(1, 2'd1, 0); tick(1, 2'd1, 0); tick(1, 2'd1, 0);
        check("t4_green3_ok", 8'(ifb.dwell_err), 8'd0);
        tick(1, 2'd1, 0);
        check("t4_long_green", 8'(ifb.dwell_err), 8'd1);
        check("t4_long_unlock", 8'(ifb.locked), 8'd0);
        tick(1, 2'd0, 0); tick(1, 2'd0, 0); tick(1, 2'd1, 0); tick(1, 2'd1, 0);
        tick(1, 2'd2, 0);
        check("t4_ok_change", 8'(ifb.dwell_err), 8'd0);
        check("t4_yellow",    8'(ifb.cur_color), 8'd2);
        tick(1, 2'd2, 0); tick(1, 2'd0, 0);
        check("t4_b_count", ifb.cycle_count, 8'd1);

        // counter wrap on the default instance (starts at 3)
        tick(1, 2'd3, 0);
        tick(1, 2'd0, 0);
        for (int i = 0; i < 252; i++) begin
            tick(1, 2'd1, 0); tick(1, 2'd2, 0); tick(1, 2'd0, 0);
        end
        check("t5_count_255", ifa.cycle_count, 8'd255);
        tick(1, 2'd1, 0); tick(1, 2'd2, 0); tick(1, 2'd0, 0);
        check("t5_wrap", ifa.cycle_count, 8'd0);

        // enable held low mid-sequence
        tick(1, 2'd1, 0);
        for (int i = 0; i < 5; i++) tick(0, 2'(i), 0);
        check("t5_hold_locked", 8'(ifa.locked), 8'd1);
        check("t5_hold_cur",    8'(ifa.cur_color), 8'd1);
        check("t5_hold_code",   8'(ifa.code_err), 8'd0);
        tick(1, 2'd2, 0);
        check("t5_resume", 8'(ifa.cur_color), 8'd2);
        check("t5_resume_ok", 8'(ifa.dwell_err), 8'd0);

        // asynchronous reset while locked with sticky set
        tick(1, 2'd3, 0);
        tick(1, 2'd0, 0);
        check("t6_pre_locked", 8'(ifa.locked), 8'd1);
        check("t6_pre_sticky", 8'(ifa.err_sticky), 8'd1);
        en = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("t6_rst_locked", 8'(ifa.locked), 8'd0);
        check("t6_rst_sticky", 8'(ifa.err_sticky), 8'd0);
        check("t6_rst_count",  ifa.cycle_count, 8'd0);
        @(negedge clk);
        reset = 1'b1;
        tick(1, 2'd1, 0);
        check("t6_no_lock_green", 8'(ifa.locked), 8'd0);
        tick(1, 2'd0, 0);
        check("t6_relock", 8'(ifa.locked), 8'd1);

        // error and clear on the same edge
        tick(1, 2'd3, 1);
        check("t7_set_wins", 8'(ifa.err_sticky), 8'd1);
        tick(1, 2'd0, 1);
        check("t7_cleared", 8'(ifa.err_sticky), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/light_monitor.md
# light_monitor

Checks the 2-bit color stream produced by the traffic-light controller. It locks onto the red→green→yellow→red sequence, enforces per-color dwell limits, and counts completed light cycles. It flags illegal codes, out-of-order transitions and dwell violations. It sits beside the controller and feeds the board's status/debug logic.

## Interface
- MIN_DWELL, default 1: minimum consecutive samples a color must hold before a legal change.
- MAX_DWELL, default 1: maximum consecutive samples a color may hold. Must be ≥ MIN_DWELL and ≤ 255.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset. 0 forces every register to its reset value immediately.
- en  input  1  sample enable. When 0, all state holds.
- color  input  2  observed light code: 00 red, 01 green, 10 yellow, 11 illegal.
- clr_err  input  1  clears err_sticky.
- locked  output  1  1 while tracking a valid sequence.
- cur_color  output  2  last accepted color while locked.
- seq_err  output  1  one-cycle pulse on an out-of-order transition.
- code_err  output  1  one-cycle pulse on code 11.
- dwell_err  output  1  one-cycle pulse on a dwell violation.
- err_sticky  output  1  set by any error pulse, held until cleared.
- cycle_count  output  8  completed yellow→red returns, wraps modulo 256.

## Operation
- FSM states: SYNC, RED, GREEN, YELLOW. An 8-bit dwell counter tracks consecutive samples of the current color.
- A sample is taken only at a rising edge with en=1. With en=0, state, counters and sticky hold, and all pulses are 0.
- Priority for each sample: code_err, then dwell_err, then seq_err. At most one pulse fires per sample.
- Any state, color=11: pulse code_err, go to SYNC, dwell=0.
- In SYNC:
  - color=00: go to RED, dwell=1.
  - Green or yellow: stay in SYNC, no error.
- In a tracked state, sample equals the current color:
  - dwell < MAX_DWELL: dwell+1.
  - dwell == MAX_DWELL: pulse dwell_err, go to SYNC, dwell=0.
- In a tracked state, sample equals the expected next color (RED→green, GREEN→yellow, YELLOW→red):
  - dwell < MIN_DWELL: pulse dwell_err, go to SYNC.
  - Otherwise: advance to the next state with dwell=1.
  - The YELLOW→RED advance also increments cycle_count (255→0 wraps).
- In a tracked state, any other legal color: pulse seq_err, go to SYNC, dwell=0.
- Re-lock after an error needs a fresh red sample taken after entering SYNC. The offending sample is not reused.
- locked = 1 in RED/GREEN/YELLOW, 0 in SYNC. cur_color follows the state and is 00 in SYNC.
- err_sticky: set when any pulse fires. Cleared by clr_err=1 at a rising edge. If an error and clr_err occur on the same edge, set wins. clr_err acts regardless of en.

## Timing
- All outputs are registered.
- A color sampled at edge n is reflected in locked, cur_color, pulses and cycle_count immediately after edge n. Latency is one edge.
- Error pulses last exactly one clock. They deassert at the next edge, or stay 0 if en is low.
- Reset values: state SYNC, dwell 0, locked 0, cur_color 00, seq_err/code_err/dwell_err 0, err_sticky 0, cycle_count 0.
- Reset asserted mid-sequence clears outputs asynchronously, without waiting for a clock. The first edge after release samples normally and needs a red to lock.
- Defaults (MIN=MAX=1) match a controller that changes color every clock. Any repeated color is a dwell_err.

## Test plan
- Defaults, en=1, after reset drive 00,01,10,00,01,10,00,01,10,00 → locked=1 from the first edge, cycle_count=3, no pulses, err_sticky=0.
- Locked in GREEN, drive 11 → code_err=1 for one cycle, locked=0, cur_color=00, err_sticky=1. Then drive 00 → locked=1.
- Locked in RED, drive 10 → seq_err pulse, locked=0. Next sample 00 relocks with cycle_count unchanged.
- MIN_DWELL=2, MAX_DWELL=3:
  - Green held 1 sample then yellow → dwell_err.
  - Green held 3 samples then a 4th green → dwell_err on the 4th.
  - Green held 2 samples then yellow → no error.
- Run 256 legal cycles → cycle_count wraps to 0. Hold en=0 for 5 clocks mid-sequence → no change to any output.
- Assert reset low between edges while locked with err_sticky=1 → all outputs 0 before the next edge. Error and clr_err on the same edge → err_sticky stays 1.
